cond_exec_stage: RTL and testbench
==================================

Name: cond_exec_stage

Overview:
- Execute-to-memory boundary stage directly downstream of the ALU.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field of each instruction against the current flags.
- Squashes write enables of failed-condition instructions and updates flags from the ALU's aluFlags.
- Registers the result into a single valid/ready pipeline slot feeding the memory/writeback stage.

Parameters:
- WIDTH, 32, datapath width of alu_result / out_result

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept this cycle
- cond  in  4  condition field
- alu_flags  in  4  from ALU: [3]=N [2]=Z [1]=C [0]=V
- alu_result  in  WIDTH  ALU output
- flag_write  in  2  [1] updates N,Z; [0] updates C,V
- reg_write_in  in  1  register-write request
- mem_write_in  in  1  memory-write request
- pc_src_in  in  1  PC-write request
- wa_in  in  4  destination register address
- flush  in  1  kill incoming and held instruction
- out_valid  out  1  output slot holds an instruction
- out_ready  in  1  downstream accepts
- out_result  out  WIDTH  registered alu_result
- out_wa  out  4  registered wa_in
- reg_write_out  out  1  reg_write_in & cond_pass, registered
- mem_write_out  out  1  mem_write_in & cond_pass, registered
- pc_src_out  out  1  pc_src_in & cond_pass, registered
- cond_pass_out  out  1  registered cond_pass
- flags_out  out  4  current flag register, NZCV order as alu_flags

Behaviour:
- Reset (async, immediate): flags=4'b0000; out_valid=0; every registered output=0.
- in_ready = ~out_valid | out_ready. It is combinational and never depends on in_valid.
- accept = in_valid & in_ready & ~flush.
- cond_pass is combinational from cond and the flag register value before this cycle's update:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (never)
- On accept, at the next edge:
  - Output slot is loaded and out_valid=1.
  - Enables are ANDed with cond_pass.
  - If cond_pass: flags[3:2] <= alu_flags[3:2] when flag_write[1]; flags[1:0] <= alu_flags[1:0] when flag_write[0].
  - If cond_pass=0: flags are unchanged. The instruction still occupies the slot with all enables 0.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 per cycle while out_ready=1.
- Back-to-back: the second instruction sees flags written by the first. The register updates at the edge of the first accept, so no bypass is needed.
- Stall: out_valid & ~out_ready holds all outputs stable and keeps in_ready=0. Flags are not touched.
- Slot drains: out_valid & out_ready & ~accept drives out_valid to 0 at the next edge.
- flush=1, at the next edge:
  - out_valid=0.
  - The incoming instruction is dropped; flags do not update even if cond_pass.
  - flush has priority over out_ready and in_valid.
- Data outputs when out_valid=0 hold their last value. They are don't-care except after reset, when they are 0.

Optional Feature:
- Macro: COND_STATS_EN.
- Defined:
  - Adds output ports exec_count [31:0] and squash_count [31:0], both reset to 0.
  - On each accept, exec_count increments if cond_pass, else squash_count increments.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Flushed instructions are not counted.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package cond_pkg holds:
  - typedef enum logic [3:0] cond_e covering EQ..AL and NV=4'hF.
  - Flag index localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module cond_check: purely combinational, (cond, flags) -> cond_pass. It is reusable by branch logic.
- The flag register and the pipeline slot stay in the top.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert reset while out_valid=1 and flags=4'b1111.
  - Response: out_valid, flags_out and every registered output go to 0 immediately, without waiting for a clock edge; in_ready=1.
- Flag update and condition chain:
  - Stimulus: accept AL with flag_write=2'b11 and alu_flags=4'b0100; next cycle accept EQ with reg_write_in=1.
  - Response: flags_out=4'b0100; second output reg_write_out=1, cond_pass_out=1.
- Squash:
  - Stimulus: flags=4'b0100; accept NE with reg_write_in=1, mem_write_in=1, flag_write=2'b11, alu_flags=4'b1010.
  - Response: out_valid=1 with reg_write_out=0, mem_write_out=0, cond_pass_out=0; flags_out stays 4'b0100.
- Signed conditions:
  - Stimulus: flags=4'b1000 (N=1, V=0); evaluate GE, LT, GT, LE.
  - Response: cond_pass = 0, 1, 0, 1 respectively.
  - Stimulus: cond=4'hF.
  - Response: cond_pass=0.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid=1.
  - Response: in_ready=0; out_result stable at 32'h0000_00AA; flags unchanged.
  - Stimulus: release out_ready.
  - Response: the next instruction is accepted in the same cycle.
- Flush priority:
  - Stimulus: flush=1, in_valid=1, out_ready=1, flag_write=2'b11, AL.
  - Response: out_valid=0 next cycle; flags unchanged; with COND_STATS_EN, neither counter increments.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types for condition-code evaluation: condition mnemonics, NZCV flag indices,
// per-instruction side-effect enables and the flag merge helper.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic pc_src;
    } en_t;

    // flag_write[1] owns N,Z and flag_write[0] owns C,V.
    function automatic logic [3:0] merge_flags(input logic [3:0] old_flags,
                                               input logic [3:0] new_flags,
                                               input logic [1:0] flag_write);
        logic [3:0] res;
        res = old_flags;
        if (flag_write[1]) begin
            res[FLAG_N] = new_flags[FLAG_N];
            res[FLAG_Z] = new_flags[FLAG_Z];
        end
        if (flag_write[0]) begin
            res[FLAG_C] = new_flags[FLAG_C];
            res[FLAG_V] = new_flags[FLAG_V];
        end
        return res;
    endfunction

endpackage

// File: rtl/cond_check.sv
// Condition-field evaluator: (cond, NZCV) -> pass. Purely combinational, zero latency,
// no flow control; shared with branch resolution.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_pass_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    always_comb begin
        cond_pass_o = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ: cond_pass_o = z;
            COND_NE: cond_pass_o = ~z;
            COND_CS: cond_pass_o = c;
            COND_CC: cond_pass_o = ~c;
            COND_MI: cond_pass_o = n;
            COND_PL: cond_pass_o = ~n;
            COND_VS: cond_pass_o = v;
            COND_VC: cond_pass_o = ~v;
            COND_HI: cond_pass_o = c & ~z;
            COND_LS: cond_pass_o = ~c | z;
            COND_GE: cond_pass_o = (n == v);
            COND_LT: cond_pass_o = (n != v);
            COND_GT: cond_pass_o = ~z & (n == v);
            COND_LE: cond_pass_o = z | (n != v);
            COND_AL: cond_pass_o = 1'b1;
            COND_NV: cond_pass_o = 1'b0;
            default: cond_pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// EX->MEM stage: owns NZCV, squashes failed-condition enables, one registered output slot.
// Latency 1 cycle; in_ready = ~out_valid | out_ready; flush wins. COND_STATS_EN adds counters.
module cond_exec_stage
    import cond_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [1:0]       flag_write,
    input  logic             reg_write_in,
    input  logic             mem_write_in,
    input  logic             pc_src_in,
    input  logic [3:0]       wa_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_wa,
    output logic             reg_write_out,
    output logic             mem_write_out,
    output logic             pc_src_out,
    output logic             cond_pass_out,
    output logic [3:0]       flags_out
`ifdef COND_STATS_EN
    ,
    output logic [31:0]      exec_count,
    output logic [31:0]      squash_count
`endif
);

    logic [3:0]       flags_q, flags_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       wa_q, wa_d;
    en_t              en_q, en_d;
    logic             pass_q, pass_d;

    logic cond_pass;
    logic accept;
    en_t  en_in;

    cond_check u_cond_check (
        .cond_i      (cond),
        .flags_i     (flags_q),
        .cond_pass_o (cond_pass)
    );

    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    assign en_in.reg_write = reg_write_in & cond_pass;
    assign en_in.mem_write = mem_write_in & cond_pass;
    assign en_in.pc_src    = pc_src_in & cond_pass;

    // Flags update at the accept edge, so a back-to-back consumer reads them directly.
    always_comb begin
        flags_d = flags_q;
        if (accept && cond_pass) begin
            flags_d = merge_flags(flags_q, alu_flags, flag_write);
        end
    end

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        wa_d     = wa_q;
        en_d     = en_q;
        pass_d   = pass_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            result_d = alu_result;
            wa_d     = wa_in;
            en_d     = en_in;
            pass_d   = cond_pass;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q  <= 4'b0000;
            valid_q  <= 1'b0;
            result_q <= '0;
            wa_q     <= 4'h0;
            en_q     <= '0;
            pass_q   <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            wa_q     <= wa_d;
            en_q     <= en_d;
            pass_q   <= pass_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_result    = result_q;
    assign out_wa        = wa_q;
    assign reg_write_out = en_q.reg_write;
    assign mem_write_out = en_q.mem_write;
    assign pc_src_out    = en_q.pc_src;
    assign cond_pass_out = pass_q;
    assign flags_out     = flags_q;

`ifdef COND_STATS_EN
    logic [31:0] exec_q, exec_d;
    logic [31:0] squash_q, squash_d;

    // Saturating: a stuck counter at all-ones is more useful than a silent wrap.
    always_comb begin
        exec_d   = exec_q;
        squash_d = squash_q;
        if (accept) begin
            if (cond_pass) begin
                if (exec_q != 32'hFFFF_FFFF) exec_d = exec_q + 32'd1;
            end else begin
                if (squash_q != 32'hFFFF_FFFF) squash_d = squash_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_q   <= 32'd0;
            squash_q <= 32'd0;
        end else begin
            exec_q   <= exec_d;
            squash_q <= squash_d;
        end
    end

    assign exec_count   = exec_q;
    assign squash_count = squash_q;
`endif

endmodule

// File: tb/tb_cond_exec_stage.sv
// Bench for cond_exec_stage: table of condition vectors, directed corner sequences,
// then randomized traffic against a transaction-level model.
module tb_cond_exec_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       cond;
    logic [3:0]       alu_flags;
    logic [WIDTH-1:0] alu_result;
    logic [1:0]       flag_write;
    logic             reg_write_in;
    logic             mem_write_in;
    logic             pc_src_in;
    logic [3:0]       wa_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_wa;
    logic             reg_write_out;
    logic             mem_write_out;
    logic             pc_src_out;
    logic             cond_pass_out;
    logic [3:0]       flags_out;
`ifdef COND_STATS_EN
    logic [31:0]      exec_count;
    logic [31:0]      squash_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cond_exec_stage #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .cond          (cond),
        .alu_flags     (alu_flags),
        .alu_result    (alu_result),
        .flag_write    (flag_write),
        .reg_write_in  (reg_write_in),
        .mem_write_in  (mem_write_in),
        .pc_src_in     (pc_src_in),
        .wa_in         (wa_in),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_wa        (out_wa),
        .reg_write_out (reg_write_out),
        .mem_write_out (mem_write_out),
        .pc_src_out    (pc_src_out),
        .cond_pass_out (cond_pass_out),
        .flags_out     (flags_out)
`ifdef COND_STATS_EN
        ,
        .exec_count    (exec_count),
        .squash_count  (squash_count)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] c, input logic [3:0] af,
                         input logic [31:0] res, input logic [1:0] fw, input logic rw,
                         input logic mw, input logic pc, input logic [3:0] wa,
                         input logic fl, input logic ordy);
        in_valid = iv; cond = c; alu_flags = af; alu_result = res; flag_write = fw;
        reg_write_in = rw; mem_write_in = mw; pc_src_in = pc; wa_in = wa;
        flush = fl; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Condition rule from the architectural table: even codes test a predicate, odd codes its inverse.
    function automatic logic pass_of(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return base ^ c[0];
    endfunction

    typedef struct {
        logic [3:0] flags;
        logic [3:0] c;
        logic       exp;
    } vec_t;

    vec_t tbl[20];

    // Transaction-level model state
    logic        m_valid;
    logic [3:0]  m_flags;
    logic [31:0] m_res;
    logic [3:0]  m_wa;
    logic        m_rw, m_mw, m_pc, m_cp;
    int unsigned m_exec, m_squash;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  fsave;
        logic        rdy_exp, acc, p;
        logic        iv, fl, ordy, rw, mw, pc;
        logic [3:0]  c, af, wa;
        logic [1:0]  fw;
        logic [31:0] res;
`ifdef COND_STATS_EN
        logic [31:0] ec, sc;
`endif

        tbl[0]  = '{4'b1000, 4'hA, 1'b0};
        tbl[1]  = '{4'b1000, 4'hB, 1'b1};
        tbl[2]  = '{4'b1000, 4'hC, 1'b0};
        tbl[3]  = '{4'b1000, 4'hD, 1'b1};
        tbl[4]  = '{4'b1000, 4'hF, 1'b0};
        tbl[5]  = '{4'b1000, 4'h4, 1'b1};
        tbl[6]  = '{4'b1000, 4'h5, 1'b0};
        tbl[7]  = '{4'b0100, 4'h0, 1'b1};
        tbl[8]  = '{4'b0100, 4'h1, 1'b0};
        tbl[9]  = '{4'b0100, 4'h9, 1'b1};
        tbl[10] = '{4'b0110, 4'h8, 1'b0};
        tbl[11] = '{4'b0010, 4'h8, 1'b1};
        tbl[12] = '{4'b0010, 4'h2, 1'b1};
        tbl[13] = '{4'b0010, 4'h3, 1'b0};
        tbl[14] = '{4'b0001, 4'h6, 1'b1};
        tbl[15] = '{4'b0001, 4'h7, 1'b0};
        tbl[16] = '{4'b0001, 4'hA, 1'b0};
        tbl[17] = '{4'b1001, 4'hC, 1'b1};
        tbl[18] = '{4'b1101, 4'hC, 1'b0};
        tbl[19] = '{4'b1101, 4'hD, 1'b1};

        // Reset state
        reset = 1'b1;
        drive(0, 4'h0, 4'h0, 32'h0, 2'b00, 0, 0, 0, 4'h0, 0, 1);
        #12;
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_flags", {60'd0, flags_out}, 64'd0);
        check("rst_result", {32'd0, out_result}, 64'd0);
        check("rst_enables", {60'd0, reg_write_out, mem_write_out, pc_src_out, cond_pass_out}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b0;
        tick();

        // Flag update then dependent EQ
        drive(1, 4'hE, 4'b0100, 32'h11, 2'b11, 0, 0, 0, 4'h1, 0, 1);
        tick();
        check("chain_flags", {60'd0, flags_out}, 64'h4);
        drive(1, 4'h0, 4'b0000, 32'h22, 2'b00, 1, 0, 0, 4'h2, 0, 1);
        tick();
        check("chain_valid", {63'd0, out_valid}, 64'd1);
        check("chain_rw", {63'd0, reg_write_out}, 64'd1);
        check("chain_cp", {63'd0, cond_pass_out}, 64'd1);
        check("chain_wa", {60'd0, out_wa}, 64'h2);

        // Squash: NE fails with Z set
        drive(1, 4'h1, 4'b1010, 32'h33, 2'b11, 1, 1, 1, 4'h3, 0, 1);
        tick();
        check("squash_valid", {63'd0, out_valid}, 64'd1);
        check("squash_en", {61'd0, reg_write_out, mem_write_out, pc_src_out}, 64'd0);
        check("squash_cp", {63'd0, cond_pass_out}, 64'd0);
        check("squash_flags", {60'd0, flags_out}, 64'h4);
        check("squash_result", {32'd0, out_result}, 64'h33);

        // Condition table
        for (int i = 0; i < 20; i++) begin
            drive(1, 4'hE, tbl[i].flags, 32'h100 + i, 2'b11, 0, 0, 0, 4'h0, 0, 1);
            tick();
            drive(1, tbl[i].c, 4'hF, 32'h200 + i, 2'b00, 1, 0, 0, 4'h5, 0, 1);
            tick();
            check($sformatf("cond_tbl%0d", i), {63'd0, cond_pass_out}, {63'd0, tbl[i].exp});
            check($sformatf("cond_rw%0d", i), {63'd0, reg_write_out}, {63'd0, tbl[i].exp});
        end

        // Flush priority
        fsave = flags_out;
        drive(1, 4'hE, 4'h0, 32'h44, 2'b00, 0, 0, 0, 4'h4, 0, 1);
        tick();
`ifdef COND_STATS_EN
        ec = exec_count; sc = squash_count;
`endif
        drive(1, 4'hE, ~fsave, 32'h55, 2'b11, 1, 0, 0, 4'h5, 1, 1);
        tick();
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_flags", {60'd0, flags_out}, {60'd0, fsave});
`ifdef COND_STATS_EN
        check("flush_exec", {32'd0, exec_count}, {32'd0, ec});
        check("flush_squash", {32'd0, squash_count}, {32'd0, sc});
`endif

        // Backpressure
        fsave = flags_out;
        drive(1, 4'hE, 4'h0, 32'hAA, 2'b00, 0, 0, 0, 4'h6, 0, 1);
        tick();
        drive(1, 4'hE, 4'hF, 32'hBB, 2'b11, 0, 0, 0, 4'h7, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
            check("bp_result", {32'd0, out_result}, 64'hAA);
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_flags", {60'd0, flags_out}, {60'd0, fsave});
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {63'd0, in_ready}, 64'd1);
        tick();
        check("bp_release_result", {32'd0, out_result}, 64'hBB);
        check("bp_release_flags", {60'd0, flags_out}, 64'hF);

        // Reset mid-stream with flags=1111 and a held slot
        drive(0, 4'h0, 4'h0, 32'h0, 2'b00, 0, 0, 0, 4'h0, 0, 0);
        #2;
        check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_flags", {60'd0, flags_out}, 64'd0);
        check("mid_rst_result", {32'd0, out_result}, 64'd0);
        check("mid_rst_wa", {60'd0, out_wa}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        tick();
        reset = 1'b0;

        // Randomized traffic vs model
        m_valid = 0; m_flags = 0; m_res = 0; m_wa = 0;
        m_rw = 0; m_mw = 0; m_pc = 0; m_cp = 0; m_exec = 0; m_squash = 0;
        for (int n = 0; n < 400; n++) begin
            iv   = ($urandom_range(3, 0) != 0);
            fl   = ($urandom_range(9, 0) == 0);
            ordy = ($urandom_range(3, 0) != 0);
            c    = 4'($urandom);
            af   = 4'($urandom);
            fw   = 2'($urandom);
            rw   = 1'($urandom);
            mw   = 1'($urandom);
            pc   = 1'($urandom);
            wa   = 4'($urandom);
            res  = $urandom;
            drive(iv, c, af, res, fw, rw, mw, pc, wa, fl, ordy);
            #1;
            rdy_exp = !m_valid || ordy;
            check("rnd_in_ready", {63'd0, in_ready}, {63'd0, rdy_exp});
            acc = iv && rdy_exp && !fl;
            p   = pass_of(c, m_flags);
            if (acc) begin
                m_res = res; m_wa = wa; m_cp = p;
                m_rw = rw && p; m_mw = mw && p; m_pc = pc && p;
                if (p) begin
                    if (fw[1]) m_flags[3:2] = af[3:2];
                    if (fw[0]) m_flags[1:0] = af[1:0];
                    m_exec++;
                end else begin
                    m_squash++;
                end
            end
            if (fl) m_valid = 0;
            else if (acc) m_valid = 1;
            else if (ordy) m_valid = 0;
            tick();
            check("rnd_valid", {63'd0, out_valid}, {63'd0, m_valid});
            check("rnd_flags", {60'd0, flags_out}, {60'd0, m_flags});
            check("rnd_result", {32'd0, out_result}, {32'd0, m_res});
            check("rnd_wa", {60'd0, out_wa}, {60'd0, m_wa});
            check("rnd_en", {60'd0, reg_write_out, mem_write_out, pc_src_out, cond_pass_out},
                  {60'd0, m_rw, m_mw, m_pc, m_cp});
`ifdef COND_STATS_EN
            check("rnd_exec", {32'd0, exec_count}, {32'd0, m_exec});
            check("rnd_squash", {32'd0, squash_count}, {32'd0, m_squash});
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
